mon_prod_serial: RTL

Bit-serial radix-2 Montgomery product engine: computes P = A·B·2^(-k) mod M for operands up to BITLEN bits, one multiplier bit per clock. It is the responder side of the start/stop product handshake that the modular-exponentiation controller drives. The controller issues one product at a time and consumes the result on the rising edge of stop.

---
 rtl/rsa_pkg.sv | 14 +
 rtl/mon_prod_step.sv | 23 ++
 rtl/mon_prod_serial.sv | 105 ++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants and the Montgomery product engine state encoding.
// Used by mon_prod_serial, mon_exp and later RSA blocks.
package rsa_pkg;

  localparam int BITLEN     = 1024;
  localparam int LOG_BITLEN = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2
  } prod_state_e;

endpackage

// File: rtl/mon_prod_step.sv
// One radix-2 Montgomery iteration: acc' = (acc + bit*B + q*M) / 2, where q makes the sum even.
// Kept separate so the wide adder can be timed and unit-tested on its own.
module mon_prod_step #(
  parameter int BITLEN = rsa_pkg::BITLEN
) (
  input  logic [BITLEN+1:0] acc,
  input  logic              a_bit,
  input  logic [BITLEN-1:0] B,
  input  logic [BITLEN-1:0] M,
  output logic [BITLEN+1:0] acc_next
);

  logic              q;
  logic [BITLEN+1:0] sum;

  // acc < 2M and B < M keep acc + B + M below 4M, so BITLEN+2 bits never overflow.
  always_comb begin
    q        = acc[0] ^ (a_bit & B[0]);
    sum      = acc + (a_bit ? {2'b00, B} : '0) + (q ? {2'b00, M} : '0);
    acc_next = sum >> 1;
  end

endmodule

// File: rtl/mon_prod_serial.sv
// Bit-serial Montgomery product P = A*B*2^(-k) mod M, one multiplier bit per clock.
// Responder side of the start/stop handshake: stop is a level that rises once per completed product.
module mon_prod_serial #(
  parameter int BITLEN = rsa_pkg::BITLEN,
  parameter int CNT_W  = rsa_pkg::LOG_BITLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BITLEN-1:0] A,
  input  logic [BITLEN-1:0] B,
  input  logic [BITLEN-1:0] M,
  input  logic [CNT_W-1:0]  mp_count,
  output logic              stop,
  output logic [BITLEN-1:0] P
);

  import rsa_pkg::*;

  // One extra bit so the counter limit can hold BITLEN itself when mp_count is zero.
  localparam int KW = CNT_W + 1;

  prod_state_e       state;
  prod_state_e       state_next;
  logic [BITLEN-1:0] a_sr;
  logic [BITLEN-1:0] b_reg;
  logic [BITLEN-1:0] m_reg;
  logic [BITLEN+1:0] acc;
  logic [BITLEN+1:0] acc_next;
  logic [KW-1:0]     k_eff;
  logic [KW-1:0]     iter;
  logic              accept;
  logic              last_iter;
  logic [BITLEN-1:0] p_next;

  mon_prod_step #(.BITLEN(BITLEN)) u_step (
    .acc      (acc),
    .a_bit    (a_sr[0]),
    .B        (b_reg),
    .M        (m_reg),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = (iter == k_eff - KW'(1));
    // Final subtraction works modulo 2^BITLEN; the upper acc bits only matter for the compare.
    p_next     = (acc >= {2'b00, m_reg}) ? (acc[BITLEN-1:0] - m_reg) : acc[BITLEN-1:0];
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = LOOP;
        end
      end
      LOOP:    if (last_iter) state_next = SUB;
      SUB:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_reg <= '0;
      m_reg <= '0;
      acc   <= '0;
      k_eff <= '0;
      iter  <= '0;
      stop  <= 1'b0;
      P     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr  <= A;
            b_reg <= B;
            m_reg <= M;
            k_eff <= (mp_count == '0) ? KW'(BITLEN) : KW'(mp_count);
            acc   <= '0;
            iter  <= '0;
            stop  <= 1'b0;
          end
        end
        LOOP: begin
          acc  <= acc_next;
          a_sr <= a_sr >> 1;
          iter <= iter + KW'(1);
        end
        SUB: begin
          P    <= p_next;
          stop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
